// File: rtl/emb_line_overlay.sv
// rtl/emb_line_overlay.sv - AXI4-Stream embedded-line overlay with line/frame length checks
// Classifies lines into front/active/tail regions and stamps marker/frame-ID bytes on header lines.
module emb_line_overlay #(
  parameter int          DATA_W       = 16,
  parameter int          BYTE_LSB     = 4,
  parameter int          H_SIZE       = 1920,
  parameter int          V_SIZE       = 1280,
  parameter int          FRONT_LINE   = 2,
  parameter int          TAIL_LINE    = 4,
  parameter int          TAIL_EMB_IDX = 2,
  parameter int          CNT_W        = 32,
  parameter logic [7:0]  MARKER       = 8'hDA,
  parameter logic [5:0]  EMB_TYPE     = 6'h12,
  parameter logic [5:0]  RAW_TYPE     = 6'h2C
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              emb_en,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [95:0]       m_axis_tuser,
  output logic [CNT_W-1:0]  frame_id,
  output logic              err_line_len,
  output logic              err_frame_len
);

  localparam int               HDR_BEATS   = 2 * CNT_W / 8;
  localparam logic [15:0]      LAST_FRONT  = 16'(FRONT_LINE - 1);
  localparam logic [15:0]      LAST_ACTIVE = 16'(FRONT_LINE + V_SIZE - 1);
  localparam logic [15:0]      FRAME_LINES = 16'(FRONT_LINE + V_SIZE + TAIL_LINE);
  localparam logic [15:0]      ID_LINE     = 16'(FRONT_LINE + V_SIZE + TAIL_EMB_IDX);
  localparam logic [16:0]      H_LEN       = 17'(H_SIZE);
  localparam logic [15:0]      H_FIELD     = 16'(H_SIZE);
  localparam logic [CNT_W-1:0] FID_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FRONT, S_ACTIVE, S_TAIL} state_t;

  state_t             state_q, state_d, cur_state;
  logic [15:0]        col_q, col_d, cur_col;
  logic [15:0]        line_q, line_d, cur_line;
  logic [CNT_W-1:0]   fid_q, cur_fid;
  logic               emb_en_q, cur_emb_en;
  logic               accept, sof, counting, pattern_line;
  logic [7:0]         id_byte;
  logic [DATA_W-1:0]  data_d;
  logic [5:0]         type_d;
  logic               err_line_d, err_frame_d;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign sof           = accept && s_axis_tuser;
  assign frame_id      = fid_q;

  // An accepted SOF redefines the position of the beat it arrives on.
  always_comb begin
    cur_state  = sof ? S_FRONT : state_q;
    cur_col    = sof ? 16'd0 : col_q;
    cur_line   = sof ? 16'd0 : line_q;
    cur_fid    = sof ? fid_q + FID_ONE : fid_q;
    counting   = (cur_state != S_IDLE);
    cur_emb_en = (cur_col == 16'd0) ? emb_en : emb_en_q;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    if (accept && counting) begin
      state_d = cur_state;
      line_d  = cur_line;
      if (s_axis_tlast) begin
        col_d  = 16'd0;
        line_d = (cur_line == 16'hFFFF) ? cur_line : cur_line + 16'd1;
        if (cur_state == S_FRONT && cur_line == LAST_FRONT)
          state_d = S_ACTIVE;
        else if (cur_state == S_ACTIVE && cur_line == LAST_ACTIVE)
          state_d = S_TAIL;
      end else begin
        col_d = (cur_col == 16'hFFFF) ? cur_col : cur_col + 16'd1;
      end
    end
  end

  always_comb begin
    id_byte = 8'd0;
    for (int k = 0; k < CNT_W / 8; k++) begin
      if (cur_col[15:1] == 15'(k))
        id_byte = cur_fid[CNT_W-1-8*k -: 8];
    end
    pattern_line = (cur_state == S_FRONT && cur_line == 16'd0) ||
                   (cur_state == S_TAIL && cur_line == ID_LINE);
    type_d = (cur_state == S_ACTIVE) ? RAW_TYPE : EMB_TYPE;
    data_d = '0;
    if (!counting || cur_state == S_ACTIVE || !cur_emb_en)
      data_d = s_axis_tdata;
    else if (pattern_line && cur_col < 16'(HDR_BEATS))
      data_d[BYTE_LSB +: 8] = cur_col[0] ? id_byte : MARKER;
    err_line_d  = counting && s_axis_tlast && (({1'b0, cur_col} + 17'd1) != H_LEN);
    // A SOF arriving mid-line leaves col_q non-zero and is reported as a short frame.
    err_frame_d = sof && (state_q != S_IDLE) && (line_q != FRAME_LINES || col_q != 16'd0);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      col_q         <= 16'd0;
      line_q        <= 16'd0;
      fid_q         <= '0;
      emb_en_q      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      line_q        <= line_d;
      err_line_len  <= accept && err_line_d;
      err_frame_len <= err_frame_d;
      if (sof)
        fid_q <= cur_fid;
      if (accept && cur_col == 16'd0)
        emb_en_q <= emb_en;
      if (s_axis_tready)
        m_axis_tvalid <= s_axis_tvalid;
      if (accept) begin
        m_axis_tdata <= data_d;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tuser <= {32'd0, H_FIELD, 41'd0, type_d, s_axis_tuser};
      end
    end
  end

endmodule

// File: tb/tb_emb_line_overlay.sv
// tb/tb_emb_line_overlay.sv - self-checking bench for emb_line_overlay
// Scoreboard model driven by frame/line/column bookkeeping, plus a table of directed header beats.
module tb_emb_line_overlay;

  localparam int DW = 16, LSB = 4, H = 16, V = 6, FR = 2, TL = 4, IDX = 2, CW = 32;
  localparam int TOTAL = FR + V + TL;
  localparam logic [5:0] EMB = 6'h12, RAW = 6'h2C;
  localparam logic [7:0] MARK = 8'hDA;

  logic aclk, aresetn, emb_en;
  logic s_valid, s_ready, s_last, s_user, m_ready;
  logic [DW-1:0] s_data;
  logic m_valid, m_last, err_l, err_f;
  logic [DW-1:0] m_data;
  logic [95:0] m_user;
  logic [CW-1:0] frame_id;
  logic s_ready8, m_valid8, m_last8, err_l8, err_f8;
  logic [DW-1:0] m_data8;
  logic [95:0] m_user8;
  logic [7:0] frame_id8;

  emb_line_overlay #(.DATA_W(DW), .BYTE_LSB(LSB), .H_SIZE(H), .V_SIZE(V), .FRONT_LINE(FR),
    .TAIL_LINE(TL), .TAIL_EMB_IDX(IDX), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .emb_en(emb_en),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .frame_id(frame_id), .err_line_len(err_l), .err_frame_len(err_f));

  emb_line_overlay #(.DATA_W(DW), .BYTE_LSB(LSB), .H_SIZE(H), .V_SIZE(V), .FRONT_LINE(FR),
    .TAIL_LINE(TL), .TAIL_EMB_IDX(IDX), .CNT_W(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .emb_en(emb_en),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready8), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid8), .m_axis_tready(m_ready), .m_axis_tdata(m_data8),
    .m_axis_tlast(m_last8), .m_axis_tuser(m_user8),
    .frame_id(frame_id8), .err_line_len(err_l8), .err_frame_len(err_f8));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [95:0]   user;
    logic          err_l;
    logic          err_f;
  } exp_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic [5:0]    ty;
    logic          sof;
  } vec_t;

  exp_t          expq[$];
  logic [DW-1:0] cap_data[$];
  logic [95:0]   cap_user[$];
  vec_t          tbl[16];

  bit          in_frame, emb_q, prev_valid, prev_hs, rnd_emb, bubbles;
  int          m_line, m_col, bp_pct, err_l_seen, err_f_seen;
  logic [31:0] m_fid;
  int          n_pass, n_total;

  function automatic logic [95:0] mk_user(logic [5:0] ty, logic sof);
    return {32'd0, 16'(H), 41'd0, ty, sof};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_msg(string name, string detail);
    n_total++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Expected output for one accepted input beat, from the frame/line/column position.
  task automatic model_push();
    exp_t        e;
    logic [31:0] b;
    bit          active;
    e.err_f = 1'b0;
    e.err_l = 1'b0;
    e.data  = s_data;
    e.last  = s_last;
    if (s_user) begin
      e.err_f  = in_frame && (m_line != TOTAL || m_col != 0);
      m_fid    = m_fid + 32'd1;
      in_frame = 1'b1;
      m_line   = 0;
      m_col    = 0;
    end
    if (!in_frame) begin
      e.user = mk_user(EMB, s_user);
    end else begin
      if (m_col == 0) emb_q = emb_en;
      active = (m_line >= FR) && (m_line < FR + V);
      e.user = mk_user(active ? RAW : EMB, s_user);
      if (!active && emb_q) begin
        if ((m_line == 0 || m_line == FR + V + IDX) && m_col < 2 * CW / 8) begin
          if (m_col % 2 == 0) b = 32'(MARK);
          else b = (m_fid >> (CW - 8 * (m_col / 2 + 1))) & 32'hFF;
          e.data = 16'(b) << LSB;
        end else begin
          e.data = '0;
        end
      end
      e.err_l = s_last && (m_col + 1 != H);
      if (s_last) begin m_line++; m_col = 0; end
      else m_col++;
    end
    expq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    bit   is_new;
    is_new = !prev_valid || prev_hs;
    check("frame_id", 128'(frame_id), 128'(m_fid));
    if (err_l) err_l_seen++;
    if (err_f) err_f_seen++;
    if (m_valid) begin
      if (expq.size() == 0) begin
        fail_msg("extra_beat", $sformatf("got beat %0h expected none", m_data));
      end else begin
        e = expq[0];
        check("tdata", 128'(m_data), 128'(e.data));
        check("tlast", 128'(m_last), 128'(e.last));
        check("tuser", 128'(m_user), 128'(e.user));
        check("err_line_len", 128'(err_l), 128'(is_new ? e.err_l : 1'b0));
        check("err_frame_len", 128'(err_f), 128'(is_new ? e.err_f : 1'b0));
        if (m_ready) begin
          void'(expq.pop_front());
          cap_data.push_back(m_data);
          cap_user.push_back(m_user);
        end
      end
    end else begin
      check("err_idle", 128'({err_l, err_f}), 128'(0));
    end
    prev_valid = m_valid;
    prev_hs    = m_valid && m_ready;
  endtask

  task automatic tick(output bit fire);
    m_ready = ($urandom_range(0, 99) >= bp_pct);
    @(negedge aclk);
    monitor();
    fire = s_valid && s_ready;
    if (fire) model_push();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(int n);
    bit f;
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(f);
  endtask

  task automatic send_beat(logic [DW-1:0] d, logic sof, logic last);
    bit f;
    f       = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_user  = sof;
    s_last  = last;
    for (int i = 0; i < 200 && !f; i++) tick(f);
    if (!f) fail_msg("send_timeout", "got no handshake expected handshake within 200 cycles");
    s_valid = 1'b0;
  endtask

  task automatic send_line(int n, bit sof, bit rnd);
    for (int c = 0; c < n; c++) begin
      if (rnd_emb) emb_en = 1'($urandom_range(0, 1));
      send_beat(rnd ? DW'($urandom) : 16'hFFFF, sof && c == 0, c == n - 1);
      if (bubbles && $urandom_range(0, 9) == 0) idle(1);
    end
  endtask

  task automatic send_frame(int lines, int short_line, bit rnd);
    for (int l = 0; l < lines; l++) send_line((l == short_line) ? H - 1 : H, l == 0, rnd);
  endtask

  task automatic drain();
    bp_pct = 0;
    s_valid = 1'b0;
    for (int i = 0; i < 50 && expq.size() > 0; i++) idle(1);
    check("drain_empty", 128'(expq.size()), 128'(0));
  endtask

  task automatic async_reset();
    s_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", 128'(m_valid), 128'(0));
    check("rst_tdata", 128'(m_data), 128'(0));
    check("rst_tlast", 128'(m_last), 128'(0));
    check("rst_tuser", 128'(m_user), 128'(0));
    check("rst_frame_id", 128'({frame_id8, frame_id}), 128'(0));
    check("rst_err", 128'({err_l, err_f}), 128'(0));
    expq.delete();
    in_frame   = 1'b0;
    m_fid      = '0;
    m_line     = 0;
    m_col      = 0;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int el0, ef0;
    n_pass = 0; n_total = 0; bp_pct = 0; rnd_emb = 0; bubbles = 0;
    err_l_seen = 0; err_f_seen = 0; m_fid = '0;
    aresetn = 1'b1; emb_en = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_user = 1'b0; m_ready = 1'b1;

    tbl[0]  = '{0,   16'h0DA0, EMB, 1'b1};
    tbl[1]  = '{1,   16'h0000, EMB, 1'b0};
    tbl[2]  = '{2,   16'h0DA0, EMB, 1'b0};
    tbl[3]  = '{3,   16'h0000, EMB, 1'b0};
    tbl[4]  = '{6,   16'h0DA0, EMB, 1'b0};
    tbl[5]  = '{7,   16'h0010, EMB, 1'b0};
    tbl[6]  = '{8,   16'h0000, EMB, 1'b0};
    tbl[7]  = '{16,  16'h0000, EMB, 1'b0};
    tbl[8]  = '{32,  16'hFFFF, RAW, 1'b0};
    tbl[9]  = '{127, 16'hFFFF, RAW, 1'b0};
    tbl[10] = '{128, 16'h0000, EMB, 1'b0};
    tbl[11] = '{160, 16'h0DA0, EMB, 1'b0};
    tbl[12] = '{167, 16'h0010, EMB, 1'b0};
    tbl[13] = '{168, 16'h0000, EMB, 1'b0};
    tbl[14] = '{176, 16'h0000, EMB, 1'b0};
    tbl[15] = '{191, 16'h0000, EMB, 1'b0};

    @(posedge aclk);
    #1;
    async_reset();
    check("rst_s_ready", 128'(s_ready), 128'(1));
    idle(2);

    // Beats before any SOF pass through as embedded type.
    for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 1'b0, i == 2);
    drain();

    cap_data.delete();
    cap_user.delete();
    send_frame(TOTAL, -1, 1'b0);
    drain();
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].idx < cap_data.size()) begin
        check($sformatf("tbl_data[%0d]", tbl[i].idx), 128'(cap_data[tbl[i].idx]), 128'(tbl[i].data));
        check($sformatf("tbl_user[%0d]", tbl[i].idx), 128'(cap_user[tbl[i].idx]),
              128'(mk_user(tbl[i].ty, tbl[i].sof)));
      end else begin
        fail_msg("tbl_missing", $sformatf("got %0d beats expected index %0d", cap_data.size(), tbl[i].idx));
      end
    end

    bp_pct = 30; bubbles = 1;
    send_frame(TOTAL, -1, 1'b1);

    el0 = err_l_seen;
    send_frame(TOTAL, 5, 1'b1);
    drain();
    check("short_line_pulses", 128'(err_l_seen - el0), 128'(1));

    bp_pct = 30; rnd_emb = 1;
    send_frame(TOTAL, -1, 1'b1);
    rnd_emb = 0; emb_en = 1'b1;

    ef0 = err_f_seen;
    send_frame(5, -1, 1'b1);
    send_line(2, 1'b1, 1'b1);
    send_line(H - 2, 1'b0, 1'b1);
    send_line(3, 1'b1, 1'b0);
    send_line(H - 3, 1'b0, 1'b1);
    for (int l = 1; l < TOTAL; l++) send_line(H, 1'b0, 1'b1);
    drain();
    check("frame_err_pulses", 128'(err_f_seen - ef0), 128'(2));
    check("frame_id_after_7", 128'(frame_id), 128'(7));

    bp_pct = 30;
    send_frame(4, -1, 1'b1);
    send_line(5, 1'b0, 1'b1);
    async_reset();
    for (int i = 0; i < 4; i++) send_beat(DW'($urandom), 1'b0, i == 3);
    send_frame(TOTAL, -1, 1'b1);
    drain();
    check("frame_id_restart", 128'(frame_id), 128'(1));

    async_reset();
    bubbles = 0;
    for (int i = 0; i < 255; i++) send_beat(DW'($urandom), 1'b1, 1'b1);
    check("fid8_preload", 128'(frame_id8), 128'(255));
    send_beat(16'h1234, 1'b1, 1'b0);
    check("wrap_beat0", 128'(m_data8), 128'(16'h0DA0));
    check("wrap_fid8", 128'(frame_id8), 128'(0));
    check("wrap_ctl8", 128'({m_valid8, m_last8, err_l8, err_f8, s_ready8}), 128'(5'b10011));
    check("wrap_user8", 128'(m_user8), 128'(mk_user(EMB, 1'b1)));
    send_beat(16'h5678, 1'b0, 1'b0);
    check("wrap_beat1", 128'(m_data8), 128'(16'h0000));
    send_line(H - 2, 1'b0, 1'b1);
    drain();
    check("frame_id_256", 128'(frame_id), 128'(256));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/emb_line_overlay.md
# emb_line_overlay

Parametrised AXI4-Stream embedded-line overlay for the RAW sensor video path, sitting after the frame-size stage and before the CSI-2/VDMA packer. It classifies each incoming line as front-embedded, active, or tail-embedded, and overwrites embedded lines with a marker/frame-ID pattern. It drives per-line data-type sideband on `m_axis_tuser`, registers the output with full ready/valid backpressure, and flags line-length and frame-length errors.

## Interface
Parameters:
- `DATA_W`, 16: pixel/beat width.
- `BYTE_LSB`, 4: LSB position of the embedded byte in `tdata`; other bits zero on embedded beats. Requires `BYTE_LSB+8 <= DATA_W`.
- `H_SIZE`, 1920: expected beats per line.
- `V_SIZE`, 1280: active lines per frame.
- `FRONT_LINE`, 2: embedded lines before active; must be ≥1.
- `TAIL_LINE`, 4: embedded lines after active; must be ≥1.
- `TAIL_EMB_IDX`, 2: index within the tail region of the line carrying the frame ID; must be < `TAIL_LINE`.
- `CNT_W`, 32: frame-ID width; must be a multiple of 8.
- `MARKER`, 8'hDA: marker byte.
- `EMB_TYPE`, 6'h12: data type for embedded lines.
- `RAW_TYPE`, 6'h2C: data type for active lines.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `emb_en` in 1: 1 = overlay active; 0 = tdata pass-through. tuser and counters still operate. Sampled per line at the first beat.
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tdata` in DATA_W, `s_axis_tlast` in 1 (end of line), `s_axis_tuser` in 1 (SOF, first beat of frame).
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out DATA_W, `m_axis_tlast` out 1, `m_axis_tuser` out 96.
- `frame_id` out CNT_W: ID of the current frame.
- `err_line_len` out 1: one-cycle pulse.
- `err_frame_len` out 1: one-cycle pulse.

## Operation
- Accepted beat = `s_axis_tvalid & s_axis_tready`. All counters advance only on accepted beats.
- `col_cnt`: 16 bits. Cleared on accepted tlast or accepted SOF, otherwise +1. Saturates at 16'hFFFF.
- `line_cnt`: 16 bits. On accepted SOF it becomes 0 for that beat. It increments after each accepted tlast and saturates at 16'hFFFF.
- Region FSM:
  - States: IDLE, FRONT, ACTIVE, TAIL.
  - IDLE→FRONT on accepted SOF. Beats received in IDLE without SOF pass through with type EMB_TYPE and are not counted.
  - FRONT→ACTIVE after the tlast of line FRONT_LINE-1.
  - ACTIVE→TAIL after the tlast of line FRONT_LINE+V_SIZE-1.
  - TAIL holds until the next SOF. Lines beyond the tail are emitted as zeroed embedded lines.
  - An accepted SOF in any state restarts at FRONT with line_cnt 0 and col_cnt 0, including a SOF mid-line.
- frame_id:
  - Increments by 1 on each accepted SOF and wraps modulo 2^CNT_W. Reset value 0, so the first frame has ID 1.
  - The new value is used for that frame's header beat 0 onward.
- Embedded pattern, on front line 0 and tail line FRONT_LINE+V_SIZE+TAIL_EMB_IDX, when `emb_en`:
  - Beats 0..2·CNT_W/8-1: even beat carries MARKER; odd beat 2k+1 carries frame_id byte k, MSB byte first.
  - Remaining beats are zero.
- All other embedded lines are zero when `emb_en`. Active lines pass `s_axis_tdata` unchanged.
- m_axis_tuser fields:
  - bit0 = SOF.
  - [6:1] = region type: EMB_TYPE in IDLE/FRONT/TAIL, RAW_TYPE in ACTIVE.
  - [63:48] = H_SIZE.
  - All other bits 0.
- err_line_len pulses on an accepted tlast when col_cnt+1 ≠ H_SIZE.
- err_frame_len pulses on an accepted SOF when not in IDLE and line_cnt ≠ FRONT_LINE+V_SIZE+TAIL_LINE. A mid-line SOF also counts as an error.

## Timing
- One output register stage, so latency is 1 cycle from acceptance to `m_axis_tvalid`.
- `s_axis_tready = !m_axis_tvalid | m_axis_tready`, a combinational path from `m_axis_tready`. Full throughput: one beat per cycle with no bubbles.
- The output register holds tdata/tlast/tuser stable while `m_axis_tvalid & !m_axis_tready`.
- err pulses are registered and assert in the same cycle the offending beat appears on m_axis.
- Reset (asynchronous, any time, including mid-frame):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
  - frame_id=0, both err=0.
  - FSM=IDLE, col_cnt=0, line_cnt=0.
  - The in-flight beat is dropped.

## Test plan
- Default params, 2 frames of 1286×1920, tready always 1 → frame 1 header beats 0..7 = 0x0DA0,0x0000,0x0DA0,0x0000,0x0DA0,0x0000,0x0DA0,0x0010. Tail line 1284 has the same pattern. Lines 2..1281 are bit-exact input with tuser[6:1]=0x2C; others have 0x12.
- Random 30% m_axis_tready backpressure, 1 frame → output stream identical to the no-backpressure run. No beat is lost or duplicated, and data is held while stalled.
- Line 5 ends at 1919 beats → err_line_len pulses exactly once, aligned with that line's output tlast. The FSM and line count are unaffected.
- Frame of only 1000 lines, then SOF → err_frame_len=1 on the new SOF beat, the new frame restarts in FRONT, and frame_id increments.
- CNT_W=8, preload 255 frames, then one more frame → header beat 1 = 0x0000 (wrap to 0) and frame_id=0.
- Assert aresetn low for 1 cycle mid-ACTIVE → all outputs are 0 asynchronously. Subsequent non-SOF beats pass through as type 0x12 until SOF, and frame_id restarts at 1.
